// File: rtl/adder_arb_pkg.sv
// Shared constants and FSM encoding for the round-robin adder arbiter.
package adder_arb_pkg;

    localparam int NREQ_DEFAULT = 3;
    localparam int IDW_DEFAULT  = 2;
    localparam int OPW          = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups
// with the group carries rippled between groups.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry inside a group is formed from that group's carry-in only.
    always_comb begin : p_carry
        logic [32:0] c;
        c    = '0;
        c[0] = ci;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = w_g[4*k]
                     | (w_p[4*k] & c[4*k]);
            c[4*k+2] = w_g[4*k+1]
                     | (w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+1] & w_p[4*k] & c[4*k]);
            c[4*k+3] = w_g[4*k+2]
                     | (w_p[4*k+2] & w_g[4*k+1])
                     | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c[4*k]);
            c[4*k+4] = w_g[4*k+3]
                     | (w_p[4*k+3] & w_g[4*k+2])
                     | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                     | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c[4*k]);
        end
        w_c = c;
    end

    assign s  = w_p ^ w_c[31:0];
    assign co = w_c[32];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one cla32 among NREQ requesters, with a
// single-entry registered result stage (one result per cycle when drained).
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = IDW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [OPW*NREQ-1:0]  req_a,
    input  logic [OPW*NREQ-1:0]  req_b,
    input  logic [NREQ-1:0]      req_ci,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OPW-1:0]       rsp_sum,
    output logic                 rsp_co,
    output logic                 rsp_ov,
    output logic [IDW-1:0]       rsp_id
);

    state_t         r_state;
    state_t         w_stateNext;
    logic [IDW-1:0] r_rrPtr;
    logic [IDW-1:0] w_winner;
    logic           w_found;
    logic           w_canAccept;
    logic           w_xfer;
    logic [OPW-1:0] w_opA;
    logic [OPW-1:0] w_opB;
    logic           w_ci;
    logic [OPW-1:0] w_sum;
    logic           w_co;
    logic [OPW-1:0] r_sum;
    logic           r_co;
    logic           r_ov;
    logic [IDW-1:0] r_id;

    assign w_canAccept = (r_state == EMPTY) || rsp_ready;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin : p_grant
        logic [IDW-1:0] idx;
        idx      = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(r_rrPtr) + k) % NREQ);
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    // Reset gates the grant so nothing is accepted while the block is held.
    assign w_xfer = w_found && w_canAccept && !rst;

    always_comb begin : p_ready
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    always_comb begin : p_mux
        w_opA = '0;
        w_opB = '0;
        w_ci  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_winner == IDW'(k)) begin
                w_opA = req_a[k*OPW +: OPW];
                w_opB = req_b[k*OPW +: OPW];
                w_ci  = req_ci[k];
            end
        end
    end

    cla32 u_cla (
        .a  (w_opA),
        .b  (w_opB),
        .ci (w_ci),
        .s  (w_sum),
        .co (w_co)
    );

    always_comb begin : p_next
        w_stateNext = r_state;
        case (r_state)
            EMPTY:   if (w_xfer) w_stateNext = FULL;
            FULL:    if (rsp_ready && !w_xfer) w_stateNext = EMPTY;
            default: w_stateNext = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The result register only changes on a transfer, so it holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
            r_id    <= '0;
            r_rrPtr <= '0;
        end else if (w_xfer) begin
            r_sum   <= w_sum;
            r_co    <= w_co;
            r_ov    <= (w_opA[OPW-1] == w_opB[OPW-1]) && (w_sum[OPW-1] != w_opA[OPW-1]);
            r_id    <= w_winner;
            r_rrPtr <= (w_winner == IDW'(NREQ-1)) ? '0 : w_winner + 1'b1;
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_sum   = r_sum;
    assign rsp_co    = r_co;
    assign rsp_ov    = r_ov;
    assign rsp_id    = r_id;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vector table, stall and
// reset sequences, and random traffic against a behavioural model.
module tb_adder_arbiter;

    localparam int N = 3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] expSum;
        logic        expCo;
        logic        expOv;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  reqValid;
    logic [32*N-1:0] reqA;
    logic [32*N-1:0] reqB;
    logic [N-1:0]  reqCi;
    logic [N-1:0]  reqReady;
    logic          rspValid;
    logic          rspReady;
    logic [31:0]   rspSum;
    logic          rspCo;
    logic          rspOv;
    logic [1:0]    rspId;

    int vecCount  = 0;
    int missCount = 0;

    // Reference model state
    int          mPtr;
    bit          mFull;
    logic [31:0] mSum;
    bit          mCo;
    bit          mOv;
    int          mId;

    adder_arbiter #(.NREQ(N), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_a     (reqA),
        .req_b     (reqB),
        .req_ci    (reqCi),
        .req_ready (reqReady),
        .rsp_valid (rspValid),
        .rsp_ready (rspReady),
        .rsp_sum   (rspSum),
        .rsp_co    (rspCo),
        .rsp_ov    (rspOv),
        .rsp_id    (rspId)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mPtr  = 0;
        mFull = 0;
        mSum  = '0;
        mCo   = 0;
        mOv   = 0;
        mId   = 0;
    endtask

    task automatic checkRsp();
        checkOutput("rsp_valid", 64'(rspValid), 64'(mFull));
        checkOutput("rsp_sum",   64'(rspSum),   64'(mSum));
        checkOutput("rsp_co",    64'(rspCo),    64'(mCo));
        checkOutput("rsp_ov",    64'(rspOv),    64'(mOv));
        checkOutput("rsp_id",    64'(rspId),    64'(mId));
    endtask

    // Called at posedge+1; drives one cycle of inputs, checks grant, then results.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [32*N-1:0] a,
                                 input logic [32*N-1:0] b, input logic [N-1:0] ci,
                                 input logic rr);
        int          win;
        int          idx;
        bit          canAcc;
        logic [N-1:0] expReady;
        logic [31:0] aSel;
        logic [31:0] bSel;
        longint unsigned uSum;
        longint      sSum;
        reqValid = v;
        reqA     = a;
        reqB     = b;
        reqCi    = ci;
        rspReady = rr;
        canAcc   = !mFull || rr;
        win      = -1;
        for (int k = 0; k < N; k++) begin
            idx = (mPtr + k) % N;
            if (win < 0 && v[idx]) win = idx;
        end
        expReady = '0;
        if (canAcc && win >= 0) expReady[win] = 1'b1;
        #3;
        checkOutput("req_ready", 64'(reqReady), 64'(expReady));
        @(posedge clk);
        #1;
        if (canAcc && win >= 0) begin
            aSel  = a[win*32 +: 32];
            bSel  = b[win*32 +: 32];
            uSum  = longint'(aSel) + longint'(bSel) + longint'(ci[win]);
            sSum  = longint'($signed(aSel)) + longint'($signed(bSel)) + longint'(ci[win]);
            mSum  = uSum[31:0];
            mCo   = uSum[32];
            mOv   = (sSum > 64'sd2147483647) || (sSum < -64'sd2147483648);
            mId   = win;
            mPtr  = (win + 1) % N;
            mFull = 1;
        end else if (mFull && rr) begin
            mFull = 0;
        end
        checkRsp();
    endtask

    vec_t tbl[8];

    initial begin
        logic [32*N-1:0] aPk;
        logic [32*N-1:0] bPk;
        logic [N-1:0]    ciPk;
        logic [N-1:0]    vPk;
        int              r;

        tbl[0] = '{32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        tbl[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};

        // Reset asserted with requests pending: nothing granted, outputs cleared.
        rst      = 1'b1;
        reqValid = '1;
        reqA     = '0;
        reqB     = '0;
        reqCi    = '0;
        rspReady = 1'b1;
        modelReset();
        #2;
        checkOutput("rst_req_ready", 64'(reqReady), 64'(0));
        checkRsp();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, one requester at a time, checked against constants too.
        for (int i = 0; i < 8; i++) begin
            r    = i % N;
            aPk  = {$urandom, $urandom, $urandom};
            bPk  = {$urandom, $urandom, $urandom};
            ciPk = '0;
            aPk[r*32 +: 32] = tbl[i].a;
            bPk[r*32 +: 32] = tbl[i].b;
            ciPk[r] = tbl[i].ci;
            vPk     = '0;
            vPk[r]  = 1'b1;
            applyStimulus(vPk, aPk, bPk, ciPk, 1'b1);
            checkOutput("tbl_sum", 64'(rspSum), 64'(tbl[i].expSum));
            checkOutput("tbl_co",  64'(rspCo),  64'(tbl[i].expCo));
            checkOutput("tbl_ov",  64'(rspOv),  64'(tbl[i].expOv));
            checkOutput("tbl_id",  64'(rspId),  64'(r));
        end

        // Mid-cycle reset while FULL: result discarded at once, pointer back to 0.
        applyStimulus(3'b010, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 3'b111, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("midrst_valid", 64'(rspValid), 64'(0));
        checkOutput("midrst_sum",   64'(rspSum),   64'(0));
        checkOutput("midrst_ready", 64'(reqReady), 64'(0));
        @(posedge clk);
        #1;
        checkRsp();
        rst = 1'b0;
        applyStimulus(3'b111, {32'd3, 32'd2, 32'd1}, {32'd30, 32'd20, 32'd10}, 3'b000, 1'b1);
        checkOutput("postrst_id",  64'(rspId),  64'(0));
        checkOutput("postrst_sum", 64'(rspSum), 64'(11));

        // All requesters held with the consumer always ready: rotating grants.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b111, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                          3'($urandom_range(0, 7)), 1'b1);
            checkOutput("rr_id", 64'(rspId), 64'((i + 1) % N));
        end

        // Consumer stalls for 3 cycles while FULL, then accepts and a new grant lands.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b111, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                          3'b101, 1'b0);
        end
        applyStimulus(3'b111, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                      3'b010, 1'b1);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
